// File: rtl/digiac_bus_sequencer.sv
// Bus-cycle sequencer: divides clk into CPU bus frames, generates CPU/VIA/phi2 timing,
// and slots DMA RAM accesses into the frame where they cannot collide with the CPU access.
module digiac_bus_sequencer #(
    parameter int CYCLE_LEN = 50,
    parameter int VIA_FIRST = 8,
    parameter int VIA_STEP  = 8,
    parameter int VIA_COUNT = 4,
    parameter int PHI2_FALL = 24,
    parameter int DMA_FIRST = 4,
    parameter int DMA_LAST  = 44
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt,
    output logic        cpu_clken,
    output logic        cpu_clken1,
    output logic        via_clken,
    output logic        phi2,
    input  logic [12:0] cpu_addr,
    input  logic        cpu_we,
    input  logic        cpu_ram_sel,
    input  logic [7:0]  cpu_wdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [12:0] dma_addr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic        ram_en,
    output logic        ram_we,
    output logic [12:0] ram_addr,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata
);

    localparam int CW = $clog2(CYCLE_LEN);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPT,
        ACK
    } dma_state_t;

    dma_state_t  state;
    dma_state_t  state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic        wrap;
    logic        halted;
    logic        dma_window;
    logic        accept;
    logic        dma_we_q;
    logic [12:0] dma_addr_q;
    logic [7:0]  dma_wdata_q;

    function automatic logic via_hit(input logic [CW-1:0] c);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < VIA_COUNT; k++) begin
            if (int'(c) == VIA_FIRST + k * VIA_STEP) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    assign wrap       = (cnt == CW'(CYCLE_LEN - 1));
    assign cnt_next   = wrap ? '0 : cnt + 1'b1;
    assign dma_window = halted || ((int'(cnt) >= DMA_FIRST) && (int'(cnt) <= DMA_LAST));

    // Timing outputs are registered from the next counter value so each pulse lands on its cnt slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            halted     <= 1'b0;
            cpu_clken  <= 1'b0;
            cpu_clken1 <= 1'b0;
            via_clken  <= 1'b0;
            phi2       <= 1'b0;
            dma_ack    <= 1'b0;
            dma_rdata  <= 8'h00;
            state      <= IDLE;
        end else begin
            cnt        <= cnt_next;
            cpu_clken  <= wrap && !halt;
            cpu_clken1 <= cpu_clken;
            via_clken  <= via_hit(cnt_next);
            if (wrap) begin
                halted <= halt;
            end
            if (cpu_clken) begin
                phi2 <= 1'b1;
            end else if (cnt == CW'(PHI2_FALL)) begin
                phi2 <= 1'b0;
            end
            state   <= state_next;
            dma_ack <= (state == CAPT);
            if (state == CAPT) begin
                dma_rdata <= ram_rdata;
            end
        end
    end

    // Request fields are captured once so the requester may change them during the transfer.
    always_ff @(posedge clk) begin
        if (accept) begin
            dma_we_q    <= dma_we;
            dma_addr_q  <= dma_addr;
            dma_wdata_q <= dma_wdata;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (dma_req && dma_window) begin
                    accept     = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE:   state_next = CAPT;
            CAPT:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The CPU owns the RAM port in its access slot; otherwise the latched DMA request drives it.
    always_comb begin
        ram_en    = cpu_clken1 || (state == ISSUE);
        ram_we    = dma_we_q && (state == ISSUE);
        ram_addr  = dma_addr_q;
        ram_wdata = dma_wdata_q;
        if (cpu_clken1) begin
            ram_we    = cpu_we && cpu_ram_sel;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end
    end

endmodule

// File: tb/tb_digiac_bus_sequencer.sv
// Self-checking bench for digiac_bus_sequencer: a frame-level reference model predicts every
// output each cycle while directed and randomized steps drive halt, CPU and DMA traffic.
module tb_digiac_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        cpu_clken;
    logic        cpu_clken1;
    logic        via_clken;
    logic        phi2;
    logic [12:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_ram_sel;
    logic [7:0]  cpu_wdata;
    logic        dma_req;
    logic        dma_we;
    logic [12:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic        dma_ack;
    logic [7:0]  dma_rdata;
    logic        ram_en;
    logic        ram_we;
    logic [12:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;

    always #5 clk = ~clk;

    digiac_bus_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .halt        (halt),
        .cpu_clken   (cpu_clken),
        .cpu_clken1  (cpu_clken1),
        .via_clken   (via_clken),
        .phi2        (phi2),
        .cpu_addr    (cpu_addr),
        .cpu_we      (cpu_we),
        .cpu_ram_sel (cpu_ram_sel),
        .cpu_wdata   (cpu_wdata),
        .dma_req     (dma_req),
        .dma_we      (dma_we),
        .dma_addr    (dma_addr),
        .dma_wdata   (dma_wdata),
        .dma_ack     (dma_ack),
        .dma_rdata   (dma_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata)
    );

    // Synchronous RAM attached to the sequencer's port (read-before-write).
    logic [7:0] mem [0:8191];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    int tests = 0;
    int failures = 0;

    // Reference model: position in frame, whether this frame carries a CPU cycle, DMA phase.
    int         mcnt;
    bit         mrun;
    bit         mhalted;
    int         dphase;
    bit         lwe;
    logic [12:0] laddr;
    logic [7:0] lwdata;
    logic [7:0] mcap;
    logic [7:0] mrdata;
    bit         rd_valid;
    logic [7:0] shadow [0:8191];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_via(input int c);
        bit hit = 1'b0;
        for (int k = 0; k < 4; k++) if (c == 8 + 8 * k) hit = 1'b1;
        return hit;
    endfunction

    task automatic check_output();
        bit e_clken  = mrun && (mcnt == 0);
        bit e_clken1 = mrun && (mcnt == 1);
        bit e_phi2   = mrun && (mcnt >= 1) && (mcnt <= 24);
        bit e_issue  = (dphase == 1);
        check("cpu_clken", 16'(cpu_clken), 16'(e_clken));
        check("cpu_clken1", 16'(cpu_clken1), 16'(e_clken1));
        check("via_clken", 16'(via_clken), 16'(exp_via(mcnt)));
        check("phi2", 16'(phi2), 16'(e_phi2));
        check("issue_not_in_cpu_slot", 16'(e_issue && e_clken1), 16'(0));
        check("ram_en", 16'(ram_en), 16'(e_clken1 || e_issue));
        if (e_clken1) begin
            check("ram_we_cpu", 16'(ram_we), 16'(cpu_we && cpu_ram_sel));
            check("ram_addr_cpu", 16'(ram_addr), 16'(cpu_addr));
            check("ram_wdata_cpu", 16'(ram_wdata), 16'(cpu_wdata));
        end else if (e_issue) begin
            check("ram_we_dma", 16'(ram_we), 16'(lwe));
            check("ram_addr_dma", 16'(ram_addr), 16'(laddr));
            if (lwe) check("ram_wdata_dma", 16'(ram_wdata), 16'(lwdata));
        end else begin
            check("ram_we_idle", 16'(ram_we), 16'(0));
        end
        check("dma_ack", 16'(dma_ack), 16'(dphase == 3));
        if (rd_valid) check("dma_rdata", 16'(dma_rdata), 16'(mrdata));
    endtask

    task automatic model_advance();
        bit e_clken1 = mrun && (mcnt == 1);
        if (reset) begin
            mcnt = 0; mrun = 0; mhalted = 0; dphase = 0; mrdata = 8'h00; rd_valid = 1;
            return;
        end
        if (e_clken1 && cpu_we && cpu_ram_sel) shadow[cpu_addr] = cpu_wdata;
        case (dphase)
            0: if (dma_req && (mhalted || (mcnt >= 4 && mcnt <= 44))) begin
                   lwe = dma_we; laddr = dma_addr; lwdata = dma_wdata; dphase = 1;
               end
            1: begin
                   mcap = shadow[laddr];
                   if (lwe) shadow[laddr] = lwdata;
                   dphase = 2;
               end
            2: begin
                   mrdata = mcap; rd_valid = !lwe; dphase = 3;
               end
            default: dphase = 0;
        endcase
        if (mcnt == 49) begin
            mhalted = halt;
            mrun = !halt;
        end
        mcnt = (mcnt + 1) % 50;
    endtask

    task automatic step();
        @(negedge clk);
        check_output();
        @(posedge clk);
        model_advance();
        #1;
        cpu_addr    = 13'($urandom_range(0, 15));
        cpu_we      = 1'($urandom);
        cpu_ram_sel = 1'($urandom);
        cpu_wdata   = 8'($urandom);
    endtask

    task automatic apply_stimulus(input bit h, input bit req, input bit we,
                                  input logic [12:0] addr, input logic [7:0] wd);
        halt = h; dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wd;
    endtask

    initial begin
        int n;
        for (int a = 0; a < 8192; a++) begin
            mem[a] = 8'(a ^ 8'h5A);
            shadow[a] = 8'(a ^ 8'h5A);
        end
        reset = 1'b1;
        cpu_addr = '0; cpu_we = 0; cpu_ram_sel = 0; cpu_wdata = '0;
        apply_stimulus(0, 0, 0, 13'h0, 8'h00);
        mcnt = 0; mrun = 0; mhalted = 0; dphase = 0; mrdata = 0; rd_valid = 1;

        @(posedge clk); #1;
        repeat (2) step();
        reset = 1'b0;

        // First CPU cycle arrives on the 50th edge after reset release.
        repeat (49) step();
        check("first_clken_early", 16'(cpu_clken), 16'(0));
        step();
        check("first_clken_edge50", 16'(cpu_clken), 16'(1));
        step();
        check("clken1_follows", 16'(cpu_clken1), 16'(1));
        check("clken_one_cycle", 16'(cpu_clken), 16'(0));

        // One full frame: phi2 width and VIA tick count.
        begin
            int phi_cnt = 0, via_cnt = 0;
            repeat (50) begin
                step();
                phi_cnt += int'(phi2);
                via_cnt += int'(via_clken);
            end
            check("phi2_width", 16'(phi_cnt), 16'(24));
            check("via_per_frame", 16'(via_cnt), 16'(4));
        end

        // DMA write 0xA5 to 0x0123 requested at cnt 40.
        while (mcnt != 40) step();
        apply_stimulus(0, 1, 1, 13'h0123, 8'hA5);
        step();
        apply_stimulus(0, 0, 0, 13'h1FFF, 8'h00);
        check("dma_wr_en_cnt41", 16'(ram_en), 16'(1));
        check("dma_wr_we_cnt41", 16'(ram_we), 16'(1));
        check("dma_wr_addr_cnt41", 16'(ram_addr), 16'h0123);
        check("dma_wr_data_cnt41", 16'(ram_wdata), 16'h00A5);
        step(); step();
        check("dma_wr_ack_cnt43", 16'(dma_ack), 16'(1));

        // Read it back.
        while (mcnt != 10) step();
        apply_stimulus(0, 1, 0, 13'h0123, 8'h00);
        step();
        apply_stimulus(0, 0, 1, 13'h0000, 8'hFF);
        step(); step();
        check("dma_rd_ack", 16'(dma_ack), 16'(1));
        check("dma_rd_data", 16'(dma_rdata), 16'h00A5);

        // Request at cnt 46 waits for the window of the next frame.
        while (mcnt != 46) step();
        apply_stimulus(0, 1, 0, 13'h0055, 8'h00);
        n = 0;
        do begin
            step();
            n++;
        end while (!(ram_en && !cpu_clken1 && ram_addr == 13'h0055) && n < 60);
        apply_stimulus(0, 0, 0, 13'h0, 8'h00);
        check("late_req_issue_delay", 16'(n), 16'(9));

        // Halted frame: no CPU activity; DMA at cnt 0 accepted immediately.
        while (mcnt != 45) step();
        apply_stimulus(1, 0, 0, 13'h0, 8'h00);
        while (mcnt != 0) step();
        check("halt_no_clken", 16'(cpu_clken), 16'(0));
        apply_stimulus(1, 1, 0, 13'h0077, 8'h00);
        step();
        apply_stimulus(1, 0, 0, 13'h0, 8'h00);
        check("halt_issue_cnt1", 16'(ram_en && !cpu_clken1 && ram_addr == 13'h0077), 16'(1));
        repeat (60) step();
        apply_stimulus(0, 0, 0, 13'h0, 8'h00);
        repeat (60) step();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) halt = ~halt;
            apply_stimulus(halt, ($urandom_range(0, 3) == 0), 1'($urandom),
                           13'($urandom_range(0, 15)), 8'($urandom));
            step();
        end
        apply_stimulus(0, 0, 0, 13'h0, 8'h00);
        repeat (60) step();

        // Reset during CAPT aborts the transfer.
        while (mcnt != 20) step();
        apply_stimulus(0, 1, 0, 13'h0005, 8'h00);
        n = 0;
        while (dphase != 2 && n < 10) begin
            step();
            apply_stimulus(0, 0, 0, 13'h0005, 8'h00);
            n++;
        end
        check("reached_capt", 16'(dphase), 16'(2));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_cpu_clken", 16'(cpu_clken), 16'(0));
        check("rst_cpu_clken1", 16'(cpu_clken1), 16'(0));
        check("rst_via", 16'(via_clken), 16'(0));
        check("rst_phi2", 16'(phi2), 16'(0));
        check("rst_dma_ack", 16'(dma_ack), 16'(0));
        check("rst_dma_rdata", 16'(dma_rdata), 16'(0));
        check("rst_ram_en", 16'(ram_en), 16'(0));
        repeat (20) step();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
